// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared encodings and LCD command constants for lcd_text_driver
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POR,
        ST_INIT,
        ST_CLR_WAIT,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2
    } state_t;

    typedef enum logic [1:0] {
        PH_ADDR,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam int INIT_CMDS = 5;

    // Function set is sent twice so the controller latches 8-bit mode reliably.
    function automatic logic [7:0] init_cmd(input logic [2:0] step);
        case (step)
            3'd0, 3'd1: return LCD_FUNC_SET;
            3'd2:       return LCD_DISP_ON;
            3'd3:       return LCD_ENTRY;
            default:    return LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// rtl/lcd_tick_gen.sv - free-running divider producing one-clk phase ticks
module lcd_tick_gen #(
    parameter int TICK_DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] count;

    assign tick = (count == W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_text_driver.sv
// rtl/lcd_text_driver.sv - HD44780 2x16 write-only driver refreshing 32 cells from the text formatter
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int TICK_DIV    = 5000,
    parameter int POR_TICKS   = 200,
    parameter int CLEAR_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    logic        tick;
    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [15:0] cnt, cnt_n;
    logic [4:0]  index_n;
    logic        e_n, rs_n, init_done_n, frame_done_n;
    logic [7:0]  data_n;
    logic [7:0]  cmd;
    logic        is_data;

    lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_POR;
            phase      <= PH_ADDR;
            cnt        <= '0;
            index      <= '0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_data   <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            cnt        <= cnt_n;
            index      <= index_n;
            lcd_e      <= e_n;
            lcd_rs     <= rs_n;
            lcd_rw     <= 1'b0;
            lcd_data   <= data_n;
            init_done  <= init_done_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        phase_n      = phase;
        cnt_n        = cnt;
        index_n      = index;
        e_n          = lcd_e;
        rs_n         = lcd_rs;
        data_n       = lcd_data;
        init_done_n  = init_done;
        frame_done_n = 1'b0;
        is_data      = (state == ST_LINE1) || (state == ST_LINE2);

        case (state)
            ST_INIT:  cmd = init_cmd(cnt[2:0]);
            ST_ADDR2: cmd = LCD_LINE2;
            default:  cmd = LCD_LINE1;
        endcase

        if (tick) begin
            case (state)
                ST_POR: begin
                    if (cnt == 16'(POR_TICKS - 1)) begin
                        state_n = ST_INIT;
                        phase_n = PH_ADDR;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                ST_CLR_WAIT: begin
                    if (cnt == 16'(CLEAR_TICKS - 1)) begin
                        state_n     = ST_ADDR1;
                        phase_n     = PH_ADDR;
                        cnt_n       = '0;
                        init_done_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                default: begin
                    case (phase)
                        PH_ADDR: begin
                            // The only clk on which char_in is sampled; index has been stable for a full tick.
                            phase_n = PH_SETUP;
                            data_n  = is_data ? char_in : cmd;
                            rs_n    = is_data;
                        end
                        PH_SETUP: begin
                            phase_n = PH_PULSE;
                            e_n     = 1'b1;
                        end
                        PH_PULSE: begin
                            phase_n = PH_HOLD;
                            e_n     = 1'b0;
                        end
                        default: begin
                            phase_n = PH_ADDR;
                            case (state)
                                ST_INIT: begin
                                    if (cnt == 16'(INIT_CMDS - 1)) begin
                                        state_n = ST_CLR_WAIT;
                                        cnt_n   = '0;
                                    end else begin
                                        cnt_n = cnt + 16'd1;
                                    end
                                end
                                ST_ADDR1: begin
                                    state_n = ST_LINE1;
                                    index_n = 5'd0;
                                end
                                ST_LINE1: begin
                                    if (index == 5'd15) begin
                                        state_n = ST_ADDR2;
                                    end else begin
                                        index_n = index + 5'd1;
                                    end
                                end
                                ST_ADDR2: begin
                                    state_n = ST_LINE2;
                                    index_n = 5'd16;
                                end
                                default: begin
                                    if (index == 5'd31) begin
                                        state_n      = ST_ADDR1;
                                        frame_done_n = 1'b1;
                                    end else begin
                                        index_n = index + 5'd1;
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_driver.sv
// tb/tb_lcd_text_driver.sv - scoreboard bench for lcd_text_driver
module tb_lcd_text_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0] lcd_data;

    lcd_text_driver #(.TICK_DIV(2), .POR_TICKS(3), .CLEAR_TICKS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .index      (index),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] idx;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic garbage = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input logic [4:0] idx);
        exp_t e;
        e.rs = rs; e.data = data; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic push_init();
        logic [7:0] cmds [5] = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        for (int i = 0; i < 5; i++) push(1'b0, cmds[i], 5'd0);
    endtask

    task automatic push_frame();
        push(1'b0, 8'h80, 5'd0);
        for (int i = 0; i < 16; i++) push(1'b1, 8'(8'h41 + i), 5'(i));
        push(1'b0, 8'hC0, 5'd0);
        for (int i = 16; i < 32; i++) push(1'b1, 8'(8'h41 + i), 5'(i));
    endtask

    int   c, e_w, n_strobe, fd_cnt, fd_last, fd_w, max_idx, rise_idx;
    logic prev_e, prev_fd, prev_init;

    // Monitor and formatter model; c is the number of clk edges since reset release.
    always @(negedge clk) begin
        exp_t ex;
        if (!rst) begin
            c = 0; e_w = 0; n_strobe = 0; fd_cnt = 0; fd_last = 0; fd_w = 0;
            max_idx = 0; rise_idx = 0; prev_e = 0; prev_fd = 0; prev_init = 0;
        end else begin
            c++;
            if (int'(index) > max_idx) max_idx = int'(index);
            if (lcd_e && !prev_e) begin
                n_strobe++;
                if (n_strobe == 1) begin
                    chk("first_e_clk", c, 10);
                    chk("rw", lcd_rw, 0);
                end
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, sb.size());
                end else begin
                    ex = sb.pop_front();
                    chk("rs", lcd_rs, ex.rs);
                    chk("data", lcd_data, ex.data);
                    if (ex.rs) chk("index", index, ex.idx);
                end
                rise_idx = int'(index);
                e_w = 0;
            end
            if (lcd_e) e_w++;
            if (!lcd_e && prev_e) begin
                chk("e_width", e_w, 2);
                chk("index_stable", index, rise_idx);
            end
            if (init_done && !prev_init) begin
                chk("init_clk", c, 54);
                chk("init_strobes", n_strobe, 5);
            end
            if (frame_done) fd_w++;
            if (frame_done && !prev_fd) begin
                if (fd_cnt == 0) chk("frame1_clk", c, 326);
                else chk("frame_period", c - fd_last, 272);
                chk("idx_max", max_idx, 31);
                fd_last = c;
                fd_cnt++;
            end
            if (!frame_done && prev_fd) begin
                chk("fd_width", fd_w, 1);
                fd_w = 0;
            end
            prev_e = lcd_e; prev_fd = frame_done; prev_init = init_done;
        end
        // Bytes start on edges 6 mod 8; the edge two later samples char_in.
        if (!garbage || (c >= 55 && ((c - 55) % 8) == 0))
            char_in = 8'h41 + 8'(index);
        else
            char_in = (8'h41 + 8'(index)) ^ 8'($urandom_range(255, 1));
    end

    task automatic wait_fd(input int n, input int budget);
        int k;
        k = 0;
        while (fd_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (fd_cnt < n) chk("timeout_frame", fd_cnt, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_e"}, lcd_e, 0);
        chk({tag, "_rs"}, lcd_rs, 0);
        chk({tag, "_rw"}, lcd_rw, 0);
        chk({tag, "_data"}, lcd_data, 0);
        chk({tag, "_index"}, index, 0);
        chk({tag, "_init"}, init_done, 0);
        chk({tag, "_fd"}, frame_done, 0);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        char_in = 8'h00;
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("rst");
        push_init();
        for (int f = 0; f < 5; f++) push_frame();
        @(negedge clk);
        #1 rst = 1'b1;

        wait_fd(1, 600);
        garbage = 1'b1;
        wait_fd(4, 1200);

        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (lcd_e && lcd_rs && index == 5'd7) break;
        end
        if (!(lcd_e && lcd_rs && index == 5'd7)) chk("mid_wait", 0, 1);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("mid");

        sb.delete();
        push_init();
        push_frame();
        push(1'b0, 8'h80, 5'd0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        wait_fd(1, 600);
        repeat (8) @(negedge clk);
        chk("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
